// File: rtl/program_loader_pkg.sv
// Shared definitions for the boot-time program loader: FSM states and
// stream/word geometry constants.
package loader_pkg;

    localparam int unsigned BYTES_PER_WORD = 4;
    localparam int unsigned ADDR_STEP      = 4;
    localparam int unsigned COUNT_WIDTH    = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN_LO,
        ST_LEN_HI,
        ST_DATA,
        ST_WRITE,
        ST_DONE,
        ST_ERROR
    } state_e;

endpackage

// File: rtl/program_loader_word_assembler.sv
// Collects little-endian stream bytes into one instruction word; word_full_o
// flags the byte that completes the word.
module word_assembler
    import loader_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear_i,
    input  logic                  take_i,
    input  logic [7:0]            byte_i,
    output logic [DATA_WIDTH-1:0] word_o,
    output logic                  word_full_o
);

    logic [1:0]            idx_q;
    logic [DATA_WIDTH-1:0] word_q;

    // Bytes enter at the top and shift down, so after four bytes the
    // first one received sits in [7:0].
    always_ff @(posedge clk) begin
        if (reset || clear_i) begin
            idx_q  <= '0;
            word_q <= '0;
        end else if (take_i) begin
            idx_q  <= idx_q + 2'd1;
            word_q <= {byte_i, word_q[DATA_WIDTH-1:8]};
        end
    end

    assign word_o      = word_q;
    assign word_full_o = take_i && (idx_q == 2'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/program_loader.sv
// Boot loader: reads a 16-bit word count then that many 32-bit words from a
// byte stream, writing them to program memory while holding the core stalled.
module program_loader
    import loader_pkg::*;
#(
    parameter int unsigned MEMORY_DEPTH = 32,
    parameter int unsigned DATA_WIDTH   = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  Start_i,
    input  logic [7:0]            Byte_i,
    input  logic                  Byte_Valid_i,
    output logic                  Byte_Ready_o,
    output logic                  Mem_Write_o,
    output logic [DATA_WIDTH-1:0] Mem_Address_o,
    output logic [DATA_WIDTH-1:0] Mem_Data_o,
    output logic                  Cpu_Hold_o,
    output logic                  Done_o,
    output logic                  Error_o
);

    state_e                 state_q;
    logic [COUNT_WIDTH-1:0] count_q;
    logic [COUNT_WIDTH-1:0] written_q;
    logic [DATA_WIDTH-1:0]  addr_q;

    logic                   take;
    logic                   word_full;
    logic                   asm_clear;
    logic [COUNT_WIDTH-1:0] len_d;
    logic [COUNT_WIDTH-1:0] written_d;
    logic [DATA_WIDTH-1:0]  word;

    assign Byte_Ready_o = (state_q == ST_LEN_LO) || (state_q == ST_LEN_HI) ||
                          (state_q == ST_DATA);
    assign take         = Byte_Valid_i && Byte_Ready_o;
    assign len_d        = {Byte_i, count_q[7:0]};
    assign written_d    = written_q + COUNT_WIDTH'(1);
    assign asm_clear    = (state_q == ST_IDLE) || (state_q == ST_ERROR);

    word_assembler #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_asm (
        .clk         (clk),
        .reset       (reset),
        .clear_i     (asm_clear),
        .take_i      (take && (state_q == ST_DATA)),
        .byte_i      (Byte_i),
        .word_o      (word),
        .word_full_o (word_full)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            count_q   <= '0;
            written_q <= '0;
            addr_q    <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    count_q   <= '0;
                    written_q <= '0;
                    addr_q    <= '0;
                    if (Start_i) state_q <= ST_LEN_LO;
                end
                ST_LEN_LO: begin
                    if (Byte_Valid_i) begin
                        count_q[7:0] <= Byte_i;
                        state_q      <= ST_LEN_HI;
                    end
                end
                ST_LEN_HI: begin
                    if (Byte_Valid_i) begin
                        count_q[15:8] <= Byte_i;
                        if (len_d == '0)
                            state_q <= ST_DONE;
                        else if (len_d > COUNT_WIDTH'(MEMORY_DEPTH))
                            state_q <= ST_ERROR;
                        else
                            state_q <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (word_full) state_q <= ST_WRITE;
                end
                ST_WRITE: begin
                    addr_q    <= addr_q + DATA_WIDTH'(ADDR_STEP);
                    written_q <= written_d;
                    state_q   <= (written_d == count_q) ? ST_DONE : ST_DATA;
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                ST_ERROR: begin
                    // Restart straight from ERROR without passing through IDLE.
                    if (Start_i) begin
                        count_q   <= '0;
                        written_q <= '0;
                        addr_q    <= '0;
                        state_q   <= ST_LEN_LO;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign Mem_Write_o   = (state_q == ST_WRITE);
    assign Mem_Address_o = addr_q;
    assign Mem_Data_o    = word;
    assign Cpu_Hold_o    = (state_q != ST_IDLE);
    assign Done_o        = (state_q == ST_DONE);
    assign Error_o       = (state_q == ST_ERROR);

endmodule

// File: tb/tb_program_loader.sv
// Directed and randomized load sequences for program_loader, checked against
// an expected-write list derived from the requested count and words.
module tb_program_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        Start_i;
    logic [7:0]  Byte_i;
    logic        Byte_Valid_i;
    logic        Byte_Ready_o;
    logic        Mem_Write_o;
    logic [31:0] Mem_Address_o;
    logic [31:0] Mem_Data_o;
    logic        Cpu_Hold_o;
    logic        Done_o;
    logic        Error_o;

    int errors = 0;
    int checks = 0;

    logic [31:0] got_addr[$];
    logic [31:0] got_data[$];
    int          done_seen;
    logic [31:0] words[64];

    program_loader #(
        .MEMORY_DEPTH (32),
        .DATA_WIDTH   (32)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .Start_i       (Start_i),
        .Byte_i        (Byte_i),
        .Byte_Valid_i  (Byte_Valid_i),
        .Byte_Ready_o  (Byte_Ready_o),
        .Mem_Write_o   (Mem_Write_o),
        .Mem_Address_o (Mem_Address_o),
        .Mem_Data_o    (Mem_Data_o),
        .Cpu_Hold_o    (Cpu_Hold_o),
        .Done_o        (Done_o),
        .Error_o       (Error_o)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (Mem_Write_o) begin
            got_addr.push_back(Mem_Address_o);
            got_data.push_back(Mem_Data_o);
        end
        if (Done_o) done_seen++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ready"}, Byte_Ready_o, 0);
        check({tag, "_write"}, Mem_Write_o, 0);
        check({tag, "_addr"},  Mem_Address_o, 0);
        check({tag, "_data"},  Mem_Data_o, 0);
        check({tag, "_hold"},  Cpu_Hold_o, 0);
        check({tag, "_done"},  Done_o, 0);
        check({tag, "_error"}, Error_o, 0);
    endtask

    // Present one byte and return at the falling edge after it transferred.
    task automatic send_byte(input logic [7:0] b, input bit rnd);
        int n;
        if (rnd && ($urandom_range(0, 1) == 1)) begin
            Byte_Valid_i = 1'b0;
            repeat ($urandom_range(1, 3)) @(negedge clk);
        end
        Byte_i       = b;
        Byte_Valid_i = 1'b1;
        n = 0;
        while (!Byte_Ready_o && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            checks++;
            errors++;
            $error("FAIL ready_timeout: observed=0 expected=1");
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic start_pulse();
        Start_i = 1'b1;
        @(negedge clk);
        Start_i = 1'b0;
    endtask

    task automatic compare_writes(input string tag, input int count);
        check({tag, "_nwrites"}, got_addr.size(), count);
        for (int i = 0; i < count && i < got_addr.size(); i++) begin
            check($sformatf("%s_addr%0d", tag, i), got_addr[i], 32'(4 * i));
            check($sformatf("%s_data%0d", tag, i), got_data[i], words[i]);
        end
    endtask

    // Full load of a count within MEMORY_DEPTH; glitch_byte selects a data
    // byte during which Start_i is also held high (-1 for none).
    task automatic run_load(input string tag, input logic [15:0] count, input bit rnd,
                            input bit timing, input int glitch_byte);
        int n;
        got_addr.delete();
        got_data.delete();
        done_seen = 0;
        start_pulse();
        check({tag, "_start_ready"}, Byte_Ready_o, 1);
        check({tag, "_start_hold"},  Cpu_Hold_o, 1);
        check({tag, "_start_err"},   Error_o, 0);
        send_byte(count[7:0], rnd);
        send_byte(count[15:8], rnd);
        if (timing && count == 0) begin
            check({tag, "_zero_done"},  Done_o, 1);
            check({tag, "_zero_write"}, Mem_Write_o, 0);
        end
        for (int w = 0; w < int'(count); w++) begin
            for (int k = 0; k < 4; k++) begin
                if (w * 4 + k == glitch_byte) Start_i = 1'b1;
                send_byte(words[w][8*k +: 8], rnd);
                Start_i = 1'b0;
            end
            if (timing) begin
                check({tag, "_wr_strobe"}, Mem_Write_o, 1);
                check({tag, "_wr_ready"},  Byte_Ready_o, 0);
            end
        end
        Byte_Valid_i = 1'b0;
        if (timing && count != 0) begin
            @(negedge clk);
            check({tag, "_done_pulse"}, Done_o, 1);
            check({tag, "_done_hold"},  Cpu_Hold_o, 1);
            @(negedge clk);
            check({tag, "_after_done"}, Done_o, 0);
            check({tag, "_release"},    Cpu_Hold_o, 0);
        end
        n = 0;
        while (Cpu_Hold_o && n < 200) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_finished"}, Cpu_Hold_o, 0);
        @(negedge clk);
        compare_writes(tag, int'(count));
        check({tag, "_done_count"}, done_seen, 1);
    endtask

    initial begin
        reset        = 1'b1;
        Start_i      = 1'b0;
        Byte_i       = 8'h00;
        Byte_Valid_i = 1'b0;
        done_seen    = 0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        reset = 1'b0;
        @(negedge clk);

        // Count 2, continuous valid, cycle-exact timing.
        words[0] = 32'h0000_0013;
        words[1] = 32'h0010_0093;
        run_load("t2", 16'd2, 1'b0, 1'b1, -1);

        // Count 0.
        run_load("t0", 16'd0, 1'b0, 1'b1, -1);

        // Count 33 exceeds depth: sticky error, no consumption, then recover.
        got_addr.delete();
        got_data.delete();
        start_pulse();
        send_byte(8'd33, 1'b0);
        send_byte(8'd0, 1'b0);
        check("err_flag", Error_o, 1);
        check("err_hold", Cpu_Hold_o, 1);
        Byte_i = 8'hA5;
        repeat (8) @(negedge clk);
        Byte_Valid_i = 1'b0;
        check("err_sticky", Error_o, 1);
        check("err_hold2",  Cpu_Hold_o, 1);
        check("err_ready",  Byte_Ready_o, 0);
        check("err_nowrite", got_addr.size(), 0);
        words[0] = $urandom;
        run_load("recover", 16'd1, 1'b0, 1'b0, -1);

        // Count 3, random words, random valid gaps.
        for (int i = 0; i < 3; i++) words[i] = $urandom;
        run_load("rnd3", 16'd3, 1'b1, 1'b0, -1);

        // Reset after two data bytes of the first word.
        got_addr.delete();
        got_data.delete();
        start_pulse();
        send_byte(8'd2, 1'b0);
        send_byte(8'd0, 1'b0);
        send_byte(8'h11, 1'b0);
        send_byte(8'h22, 1'b0);
        Byte_Valid_i = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        check_all_zero("midreset");
        reset = 1'b0;
        @(negedge clk);
        check("midreset_nowrite", got_addr.size(), 0);
        words[0] = $urandom;
        run_load("fresh", 16'd1, 1'b0, 1'b0, -1);

        // Start_i held during a DATA byte is ignored.
        for (int i = 0; i < 3; i++) words[i] = $urandom;
        run_load("glitch", 16'd3, 1'b0, 1'b0, 5);

        // Maximum count, random valid.
        for (int i = 0; i < 32; i++) words[i] = $urandom;
        run_load("max32", 16'd32, 1'b1, 1'b0, -1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
